// File: rtl/uw_search_if.sv
// Bus bundle between the UW search controller, the correlation engine,
// and the downstream result consumer.
// master: the controller side. slave: the engine/consumer side.
interface uw_search_if;
  logic        frame_start;
  logic        scan_start;
  logic [13:0] scan_base;
  logic [14:0] scan_len;
  logic        scan_done;
  logic [4:0]  scan_score;
  logic [13:0] scan_index;
  logic [1:0]  scan_rot;
  logic        res_valid;
  logic        res_ready;
  logic [13:0] res_index;
  logic [1:0]  res_rot;
  logic        res_hit;
  logic        locked;
  logic        overrun;
  logic        timeout;

  modport master (
    input  frame_start, scan_done, scan_score, scan_index, scan_rot, res_ready,
    output scan_start, scan_base, scan_len, res_valid, res_index, res_rot,
           res_hit, locked, overrun, timeout
  );

  modport slave (
    output frame_start, scan_done, scan_score, scan_index, scan_rot, res_ready,
    input  scan_start, scan_base, scan_len, res_valid, res_index, res_rot,
           res_hit, locked, overrun, timeout
  );
endinterface

// File: rtl/uw_search_ctrl.sv
// Per-frame scheduler for the UW correlation/phase-resolve engine.
// Launches one scan per frame, waits with a watchdog, grades the score,
// runs the acquire/track lock loop and emits one result record per frame.
// Optional build macro UW_ROT_CHECK_EN: in TRACK, a hit whose rotation
// differs from the locked rotation is treated as a miss (phase-slip guard).
module uw_search_ctrl #(
  parameter int TOTAL_SAMPLES = 16384,
  parameter int UW_LEN        = 16,
  parameter int SCORE_TH      = 14,
  parameter int CONFIRM_N     = 3,
  parameter int MISS_N        = 4,
  parameter int TRACK_WIN     = 8,
  parameter int TIMEOUT_CYC   = 20000
) (
  input logic        clk,
  input logic        rst,
  uw_search_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_EVAL, S_OUTPUT} state_t;
  typedef enum logic {M_ACQUIRE, M_TRACK} mode_t;

  localparam int TRK_LEN = 2 * TRACK_WIN + UW_LEN;
  localparam int WDW     = $clog2(TIMEOUT_CYC + 1);
  localparam int CW      = $clog2(CONFIRM_N + 1);
  localparam int MW      = $clog2(MISS_N + 1);

  localparam logic signed [15:0] TW_S      = 16'(TRACK_WIN);
  localparam logic signed [15:0] MAX_BASE_S = 16'(TOTAL_SAMPLES - TRK_LEN);

  state_t         state_q, state_d;
  mode_t          mode_q, mode_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [CW-1:0]  confirm_q, confirm_d;
  logic [MW-1:0]  miss_cnt_q, miss_cnt_d;
  logic [13:0]    expected_idx_q, expected_idx_d;
  logic [1:0]     locked_rot_q, locked_rot_d;
  logic [4:0]     score_q, score_d;
  logic [13:0]    idx_q, idx_d;
  logic [1:0]     rot_q, rot_d;
  logic [13:0]    base_q, base_d;
  logic [14:0]    len_q, len_d;
  logic [13:0]    res_index_q, res_index_d;
  logic [1:0]     res_rot_q, res_rot_d;
  logic           res_hit_q, res_hit_d;
  logic           overrun_q, overrun_d;
  logic           timeout_q, timeout_d;

  logic              hit_raw;
  logic              hit_cnt;
  logic signed [15:0] trk_base_s;

  assign bus.scan_start = (state_q == S_LAUNCH);
  assign bus.scan_base  = base_q;
  assign bus.scan_len   = len_q;
  assign bus.res_valid  = (state_q == S_OUTPUT);
  assign bus.res_index  = res_index_q;
  assign bus.res_rot    = res_rot_q;
  assign bus.res_hit    = res_hit_q;
  assign bus.locked     = (mode_q == M_TRACK);
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;

  // Grading: raw hit for the record, counted hit for the lock loop
  always_comb begin
    hit_raw = (score_q >= 5'(SCORE_TH));
    hit_cnt = hit_raw;
`ifdef UW_ROT_CHECK_EN
    if (mode_q == M_TRACK && rot_q != locked_rot_q) hit_cnt = 1'b0;
`endif
    trk_base_s = signed'({2'b00, expected_idx_q}) - TW_S;
  end

  // Next-state, scan setup, watchdog, lock loop and result record
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    wdog_d         = wdog_q;
    confirm_d      = confirm_q;
    miss_cnt_d     = miss_cnt_q;
    expected_idx_d = expected_idx_q;
    locked_rot_d   = locked_rot_q;
    score_d        = score_q;
    idx_d          = idx_q;
    rot_d          = rot_q;
    base_d         = base_q;
    len_d          = len_q;
    res_index_d    = res_index_q;
    res_rot_d      = res_rot_q;
    res_hit_d      = res_hit_q;
    overrun_d      = overrun_q;
    timeout_d      = timeout_q;

    if (bus.frame_start && state_q != S_IDLE) overrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          // Window is registered on entry so it is valid during LAUNCH
          if (mode_q == M_ACQUIRE) begin
            base_d = 14'd0;
            len_d  = 15'(TOTAL_SAMPLES);
          end else begin
            len_d = 15'(TRK_LEN);
            if (trk_base_s < 16'sd0)            base_d = 14'd0;
            else if (trk_base_s > MAX_BASE_S)   base_d = MAX_BASE_S[13:0];
            else                                base_d = trk_base_s[13:0];
          end
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.scan_done) begin
          score_d = bus.scan_score;
          idx_d   = bus.scan_index;
          rot_d   = bus.scan_rot;
          state_d = S_EVAL;
        end else if (wdog_q == WDW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          score_d   = 5'd0;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        if (mode_q == M_ACQUIRE) begin
          if (hit_cnt) begin
            if (confirm_q >= CW'(CONFIRM_N - 1)) begin
              confirm_d = '0;
              mode_d    = M_TRACK;
            end else begin
              confirm_d = confirm_q + 1'b1;
            end
          end else begin
            confirm_d = '0;
          end
        end else begin
          if (hit_cnt) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q >= MW'(MISS_N - 1)) begin
            miss_cnt_d = '0;
            mode_d     = M_ACQUIRE;
          end else begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end

        if (hit_cnt) begin
          expected_idx_d = idx_q;
          locked_rot_d   = rot_q;
        end

        // A TRACK miss reports the flywheel position instead of the scan
        if (!hit_cnt && mode_q == M_TRACK) begin
          res_index_d = expected_idx_q;
          res_rot_d   = locked_rot_q;
        end else begin
          res_index_d = idx_q;
          res_rot_d   = rot_q;
        end
        res_hit_d = hit_raw;
        state_d   = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mode_q         <= M_ACQUIRE;
      wdog_q         <= '0;
      confirm_q      <= '0;
      miss_cnt_q     <= '0;
      expected_idx_q <= '0;
      locked_rot_q   <= '0;
      score_q        <= '0;
      idx_q          <= '0;
      rot_q          <= '0;
      base_q         <= '0;
      len_q          <= '0;
      res_index_q    <= '0;
      res_rot_q      <= '0;
      res_hit_q      <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      wdog_q         <= wdog_d;
      confirm_q      <= confirm_d;
      miss_cnt_q     <= miss_cnt_d;
      expected_idx_q <= expected_idx_d;
      locked_rot_q   <= locked_rot_d;
      score_q        <= score_d;
      idx_q          <= idx_d;
      rot_q          <= rot_d;
      base_q         <= base_d;
      len_q          <= len_d;
      res_index_q    <= res_index_d;
      res_rot_q      <= res_rot_d;
      res_hit_q      <= res_hit_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uw_search_ctrl.sv
// Scoreboard bench for uw_search_ctrl: expected launches and result
// records are queued by the stimulus and checked by independent monitors.
module tb_uw_search_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uw_search_if bus();

  uw_search_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_launch = 0;
  int exp_launch = 0;
  int nm;

  typedef struct {
    logic [13:0] base;
    logic [14:0] len;
  } lau_t;

  typedef struct {
    logic [13:0] idx;
    logic [1:0]  rot;
    logic        hit;
    logic        lk;
    logic        full;
  } rec_t;

  lau_t lau_q[$];
  rec_t rec_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_l(input logic [13:0] b, input logic [14:0] l);
    lau_t e;
    e.base = b;
    e.len  = l;
    lau_q.push_back(e);
    exp_launch++;
  endtask

  task automatic push_r(input logic [13:0] i, input logic [1:0] r, input logic h,
                        input logic lk, input logic full);
    rec_t e;
    e.idx = i; e.rot = r; e.hit = h; e.lk = lk; e.full = full;
    rec_q.push_back(e);
  endtask

  // Launch monitor
  always @(negedge clk) begin
    lau_t el;
    if (!rst && bus.scan_start) begin
      n_launch++;
      if (lau_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_launch base=%0d len=%0d", bus.scan_base, bus.scan_len);
      end else begin
        el = lau_q.pop_front();
        chk("launch_base", 32'(bus.scan_base), 32'(el.base));
        chk("launch_len", 32'(bus.scan_len), 32'(el.len));
      end
    end
  end

  // Result record monitor
  always @(negedge clk) begin
    rec_t er;
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (rec_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_record index=%0d hit=%0d", bus.res_index, bus.res_hit);
      end else begin
        er = rec_q.pop_front();
        if (er.full) begin
          chk("rec_index", 32'(bus.res_index), 32'(er.idx));
          chk("rec_rot", 32'(bus.res_rot), 32'(er.rot));
        end
        chk("rec_hit", 32'(bus.res_hit), 32'(er.hit));
        chk("rec_locked", 32'(bus.locked), 32'(er.lk));
      end
    end
  end

  // One full frame; entered and left just after a rising edge
  task automatic frame(input logic [4:0] sc, input logic [13:0] ix, input logic [1:0] rt);
    bit seen;
    bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.scan_start) begin seen = 1; break; end
    end
    if (!seen) begin checks++; errors++; $display("FAIL launch_wait actual=none required=scan_start"); end
    @(posedge clk); #1;
    bus.scan_score = sc; bus.scan_index = ix; bus.scan_rot = rt; bus.scan_done = 1'b1;
    @(posedge clk); #1 bus.scan_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) begin seen = 1; break; end
    end
    if (!seen) begin checks++; errors++; $display("FAIL record_wait actual=none required=res_valid"); end
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.frame_start = 1'b0; bus.scan_done = 1'b0; bus.scan_score = '0;
    bus.scan_index = '0; bus.scan_rot = '0; bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scan_start", 32'(bus.scan_start), 0);
    chk("rst_scan_base", 32'(bus.scan_base), 0);
    chk("rst_scan_len", 32'(bus.scan_len), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_index", 32'(bus.res_index), 0);
    chk("rst_res_rot", 32'(bus.res_rot), 0);
    chk("rst_res_hit", 32'(bus.res_hit), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single acquire frame
    push_l(14'd0, 15'd16384); push_r(14'd100, 2'd2, 1'b1, 1'b0, 1'b1);
    frame(5'd16, 14'd100, 2'd2);
    chk("locked_after_first", 32'(bus.locked), 0);

    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;

    // Three confirming hits, frames back to back right after each handshake
    for (int i = 0; i < 3; i++) begin
      push_l(14'd0, 15'd16384); push_r(14'd100, 2'd1, 1'b1, (i == 2), 1'b1);
      frame(5'd15, 14'd100, 2'd1);
    end
    chk("locked_after_confirm", 32'(bus.locked), 1);

    // Tracking windows, including clamp at both ends
    push_l(14'd92, 15'd32);    push_r(14'd4, 2'd1, 1'b1, 1'b1, 1'b1);
    frame(5'd16, 14'd4, 2'd1);
    push_l(14'd0, 15'd32);     push_r(14'd16380, 2'd1, 1'b1, 1'b1, 1'b1);
    frame(5'd16, 14'd16380, 2'd1);
    push_l(14'd16352, 15'd32); push_r(14'd100, 2'd1, 1'b1, 1'b1, 1'b1);
    frame(5'd16, 14'd100, 2'd1);

`ifdef UW_ROT_CHECK_EN
    // Rotation slip: raw hit but counted as a miss, flywheel rot reported
    push_l(14'd92, 15'd32); push_r(14'd100, 2'd1, 1'b1, 1'b1, 1'b1);
    frame(5'd16, 14'd50, 2'd3);
    chk("rot_slip_miss_cnt", 32'(dut.miss_cnt_q), 1);
    nm = 3;
`else
    nm = 4;
`endif

    // Misses in TRACK: flywheel records, then lock drops
    for (int i = 0; i < nm; i++) begin
      push_l(14'd92, 15'd32); push_r(14'd100, 2'd1, 1'b0, (i < nm - 1), 1'b1);
      frame(5'd5, 14'd777, 2'd0);
    end
    chk("locked_after_misses", 32'(bus.locked), 0);
    chk("overrun_still_clear", 32'(bus.overrun), 0);

    // Watchdog expiry with an overrun pulse and a stalled consumer
    push_l(14'd0, 15'd16384); push_r(14'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.res_ready = 1'b0;
    bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    @(negedge clk);
    chk("overrun_set", 32'(bus.overrun), 1);
    chk("timeout_not_yet", 32'(bus.timeout), 0);
    seen = 0;
    for (int i = 0; i < 20100; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin seen = 1; break; end
    end
    if (!seen) begin checks++; errors++; $display("FAIL timeout_wait actual=none required=res_valid"); end
    chk("timeout_set", 32'(bus.timeout), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.res_valid), 1);
      chk("stall_hit", 32'(bus.res_hit), 0);
    end
    @(posedge clk); #1 bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("valid_dropped", 32'(bus.res_valid), 0);
    chk("overrun_sticky", 32'(bus.overrun), 1);
    chk("timeout_sticky", 32'(bus.timeout), 1);

    // Reset mid-scan: no further launch or record
    push_l(14'd0, 15'd16384);
    bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.scan_score = 5'd16; bus.scan_done = 1'b1;
    @(posedge clk); #1 bus.scan_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_valid", 32'(bus.res_valid), 0);
    chk("rst_mid_overrun", 32'(bus.overrun), 0);
    chk("rst_mid_timeout", 32'(bus.timeout), 0);

    chk("launch_count", 32'(n_launch), 32'(exp_launch));
    chk("launch_queue_empty", 32'(lau_q.size()), 0);
    chk("record_queue_empty", 32'(rec_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
